// File: rtl/writeback_queue_pkg.sv
// Shared constants for the writeback queue: default widths and RV32 load funct3 encodings.
package writeback_queue_pkg;

  localparam int WBQ_DWIDTH      = 32;
  localparam int WBQ_AWIDTH      = 5;
  localparam int WBQ_PC_WIDTH    = 32;
  localparam int WBQ_FUNCT_WIDTH = 3;
  localparam int WBQ_DEPTH       = 4;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

endpackage

// File: rtl/writeback_queue_if.sv
// Memory-stage / regfile / decode signals of the writeback queue, bundled with master and slave views.
interface writeback_queue_if #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int PC_WIDTH    = 32,
  parameter int FUNCT_WIDTH = 3
);
  logic                   wbq_i_ce;
  logic                   wbq_i_is_load;
  logic [FUNCT_WIDTH-1:0] wbq_i_funct3;
  logic [1:0]             wbq_i_byte_off;
  logic [DWIDTH-1:0]      wbq_i_load_data;
  logic [DWIDTH-1:0]      wbq_i_rd_data;
  logic [AWIDTH-1:0]      wbq_i_rd_addr;
  logic                   wbq_i_we_rd;
  logic                   wbq_i_change_pc;
  logic [PC_WIDTH-1:0]    wbq_i_pc;
  logic                   wbq_i_flush;
  logic                   wbq_i_rf_ready;
  logic [AWIDTH-1:0]      wbq_i_rs1_addr;
  logic [AWIDTH-1:0]      wbq_i_rs2_addr;
  logic                   wbq_o_stall;
  logic                   wbq_o_we_rd;
  logic [AWIDTH-1:0]      wbq_o_rd_addr;
  logic [DWIDTH-1:0]      wbq_o_rd_data;
  logic                   wbq_o_change_pc;
  logic [PC_WIDTH-1:0]    wbq_o_next_pc;
  logic                   wbq_o_fwd1_hit;
  logic [DWIDTH-1:0]      wbq_o_fwd1_data;
  logic                   wbq_o_fwd2_hit;
  logic [DWIDTH-1:0]      wbq_o_fwd2_data;

  modport master (
    output wbq_i_ce, wbq_i_is_load, wbq_i_funct3, wbq_i_byte_off, wbq_i_load_data,
           wbq_i_rd_data, wbq_i_rd_addr, wbq_i_we_rd, wbq_i_change_pc, wbq_i_pc,
           wbq_i_flush, wbq_i_rf_ready, wbq_i_rs1_addr, wbq_i_rs2_addr,
    input  wbq_o_stall, wbq_o_we_rd, wbq_o_rd_addr, wbq_o_rd_data, wbq_o_change_pc,
           wbq_o_next_pc, wbq_o_fwd1_hit, wbq_o_fwd1_data, wbq_o_fwd2_hit, wbq_o_fwd2_data
  );

  modport slave (
    input  wbq_i_ce, wbq_i_is_load, wbq_i_funct3, wbq_i_byte_off, wbq_i_load_data,
           wbq_i_rd_data, wbq_i_rd_addr, wbq_i_we_rd, wbq_i_change_pc, wbq_i_pc,
           wbq_i_flush, wbq_i_rf_ready, wbq_i_rs1_addr, wbq_i_rs2_addr,
    output wbq_o_stall, wbq_o_we_rd, wbq_o_rd_addr, wbq_o_rd_data, wbq_o_change_pc,
           wbq_o_next_pc, wbq_o_fwd1_hit, wbq_o_fwd1_data, wbq_o_fwd2_hit, wbq_o_fwd2_data
  );
endinterface

// File: rtl/writeback_queue_load_extend.sv
// Combinational load formatter: picks the byte/half lane from the raw word and sign/zero extends.
module writeback_queue_load_extend
  import writeback_queue_pkg::*;
#(
  parameter int DWIDTH      = WBQ_DWIDTH,
  parameter int FUNCT_WIDTH = WBQ_FUNCT_WIDTH
) (
  input  logic [FUNCT_WIDTH-1:0] funct3_i,
  input  logic [1:0]             byte_off_i,
  input  logic [DWIDTH-1:0]      word_i,
  output logic [DWIDTH-1:0]      data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    byte_lane = word_i[7:0];
    case (byte_off_i)
      2'd1:    byte_lane = word_i[15:8];
      2'd2:    byte_lane = word_i[23:16];
      2'd3:    byte_lane = word_i[31:24];
      default: byte_lane = word_i[7:0];
    endcase
    half_lane = byte_off_i[1] ? word_i[31:16] : word_i[15:0];

    data_o = word_i;
    case (funct3_i)
      F3_LB:   data_o = {{(DWIDTH-8){byte_lane[7]}}, byte_lane};
      F3_LH:   data_o = {{(DWIDTH-16){half_lane[15]}}, half_lane};
      F3_LBU:  data_o = {{(DWIDTH-8){1'b0}}, byte_lane};
      F3_LHU:  data_o = {{(DWIDTH-16){1'b0}}, half_lane};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback FIFO between memory stage and register file, with commit registers
// and newest-first forwarding of pending rd values to decode.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DWIDTH      = WBQ_DWIDTH,
  parameter int AWIDTH      = WBQ_AWIDTH,
  parameter int PC_WIDTH    = WBQ_PC_WIDTH,
  parameter int FUNCT_WIDTH = WBQ_FUNCT_WIDTH,
  parameter int DEPTH       = WBQ_DEPTH
) (
  input logic              wbq_clk,
  input logic              wbq_rst,
  writeback_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef struct packed {
    logic                we;
    logic [AWIDTH-1:0]   rd;
    logic [DWIDTH-1:0]   data;
    logic                change_pc;
    logic [PC_WIDTH-1:0] pc;
  } entry_t;

  entry_t            mem_q [DEPTH];
  ptr_t              head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_we_q, out_cp_q;
  logic [AWIDTH-1:0] out_rd_q;
  logic [DWIDTH-1:0] out_data_q;
  logic [PC_WIDTH-1:0] out_pc_q;

  logic              enq, cmt;
  entry_t            enq_entry, head_entry;
  logic [DWIDTH-1:0] load_fmt;
  logic [DWIDTH:0]   fwd1, fwd2;

  writeback_queue_load_extend #(.DWIDTH(DWIDTH), .FUNCT_WIDTH(FUNCT_WIDTH)) u_load_extend (
    .funct3_i   (bus.wbq_i_funct3),
    .byte_off_i (bus.wbq_i_byte_off),
    .word_i     (bus.wbq_i_load_data),
    .data_o     (load_fmt)
  );

  assign enq        = bus.wbq_i_ce && (count_q < CNT_W'(DEPTH)) && !bus.wbq_i_flush;
  assign cmt        = (count_q != '0) && bus.wbq_i_rf_ready && !bus.wbq_i_flush;
  assign head_entry = mem_q[head_q];

  always_comb begin
    enq_entry.we        = bus.wbq_i_we_rd && (bus.wbq_i_rd_addr != '0);
    enq_entry.rd        = bus.wbq_i_rd_addr;
    enq_entry.data      = bus.wbq_i_is_load ? load_fmt : bus.wbq_i_rd_data;
    enq_entry.change_pc = bus.wbq_i_change_pc;
    enq_entry.pc        = bus.wbq_i_pc;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.wbq_i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + ptr_t'(1);
      if (cmt) head_d = head_q + ptr_t'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(cmt);
    end
  end

  // NOTE: storage is left unreset; only entries inside head..count are ever read as valid.
  always_ff @(posedge wbq_clk) begin
    if (enq) mem_q[tail_q] <= enq_entry;
  end

  always_ff @(posedge wbq_clk or negedge wbq_rst) begin
    if (!wbq_rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      out_we_q   <= 1'b0;
      out_cp_q   <= 1'b0;
      out_rd_q   <= '0;
      out_data_q <= '0;
      out_pc_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (cmt) begin
        out_we_q   <= head_entry.we;
        out_cp_q   <= head_entry.change_pc;
        out_rd_q   <= head_entry.rd;
        out_data_q <= head_entry.data;
        out_pc_q   <= head_entry.pc;
      end else begin
        out_we_q <= 1'b0;
        out_cp_q <= 1'b0;
      end
    end
  end

  // Oldest-to-newest scan so the youngest matching entry overrides; the commit register is the fallback.
  function automatic logic [DWIDTH:0] fwd_lookup(input logic [AWIDTH-1:0] rs);
    logic [DWIDTH:0] r;
    ptr_t            idx;
    r   = '0;
    idx = head_q;
    if (rs != '0) begin
      if (out_we_q && (out_rd_q == rs)) r = {1'b1, out_data_q};
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_q + ptr_t'(k);
        if ((CNT_W'(k) < count_q) && mem_q[idx].we && (mem_q[idx].rd == rs))
          r = {1'b1, mem_q[idx].data};
      end
    end
    return r;
  endfunction

  always_comb fwd1 = fwd_lookup(bus.wbq_i_rs1_addr);
  always_comb fwd2 = fwd_lookup(bus.wbq_i_rs2_addr);

  assign bus.wbq_o_stall     = (count_q == CNT_W'(DEPTH));
  assign bus.wbq_o_we_rd     = out_we_q;
  assign bus.wbq_o_rd_addr   = out_rd_q;
  assign bus.wbq_o_rd_data   = out_data_q;
  assign bus.wbq_o_change_pc = out_cp_q;
  assign bus.wbq_o_next_pc   = out_pc_q;
  assign bus.wbq_o_fwd1_hit  = fwd1[DWIDTH];
  assign bus.wbq_o_fwd1_data = fwd1[DWIDTH-1:0];
  assign bus.wbq_o_fwd2_hit  = fwd2[DWIDTH];
  assign bus.wbq_o_fwd2_data = fwd2[DWIDTH-1:0];

endmodule
